// File: rtl/vend_ctrl_param.sv
// Coin-collection and vend controller: accumulates half-unit credit against a
// configurable price, vends with change, refunds on cancel or inactivity.
module vend_ctrl_param #(
   parameter int PRICE_HALVES = 5,
   parameter int LED_W        = 8,
   parameter int TIMEOUT_CYC  = 250_000_000,
   parameter int STEP_CYC     = 25_000_000,
   parameter int VEND_CYC     = 500_000_000,
   localparam int CW          = $clog2(PRICE_HALVES + 3)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             coin_half,
   input  logic             coin_one,
   input  logic             cancel,
   output logic [CW-1:0]    credit,
   output logic             vend,
   output logic [CW-1:0]    change,
   output logic             change_valid,
   output logic [CW-1:0]    refund,
   output logic             refund_valid,
   output logic             coin_reject,
   output logic [LED_W-1:0] led,
   output logic [1:0]       state_dbg
);

   // Pulse semantics: vend, change_valid, refund_valid and coin_reject are
   // high for exactly one cycle; change/refund hold their last amount and
   // are only meaningful in the cycle their valid pulse is high.

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int VW = $clog2(VEND_CYC + 1);
   localparam int SW = $clog2(STEP_CYC + 1);

   localparam logic [CW-1:0] PRICE_C   = CW'(PRICE_HALVES);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [VW-1:0] VEND_LAST = VW'(VEND_CYC - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_VEND    = 2'd2
   } state_t;

   state_t state_q, state_nx;

   logic [TW-1:0]    inact_q, inact_nx;
   logic [VW-1:0]    vend_cnt_q, vend_cnt_nx;
   logic [SW-1:0]    step_cnt_q, step_cnt_nx;
   logic             change_due_q, change_due_nx;

   logic [CW-1:0]    credit_nx, change_nx, refund_nx;
   logic             vend_nx, change_valid_nx, refund_valid_nx, coin_reject_nx;
   logic [LED_W-1:0] led_nx;

   logic [CW-1:0]    add;
   logic [CW-1:0]    new_credit;

   assign add        = CW'({coin_one, coin_half});
   assign new_credit = credit + add;
   assign state_dbg  = state_q;

   function automatic logic [LED_W-1:0] therm(input logic [CW-1:0] c);
      therm = '0;
      for (int i = 0; i < LED_W; i++) begin
         if (32'(c) > 32'(i)) therm[i] = 1'b1;
      end
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         inact_q      <= '0;
         vend_cnt_q   <= '0;
         step_cnt_q   <= '0;
         change_due_q <= 1'b0;
         credit       <= '0;
         vend         <= 1'b0;
         change       <= '0;
         change_valid <= 1'b0;
         refund       <= '0;
         refund_valid <= 1'b0;
         coin_reject  <= 1'b0;
         led          <= '0;
      end else begin
         state_q      <= state_nx;
         inact_q      <= inact_nx;
         vend_cnt_q   <= vend_cnt_nx;
         step_cnt_q   <= step_cnt_nx;
         change_due_q <= change_due_nx;
         credit       <= credit_nx;
         vend         <= vend_nx;
         change       <= change_nx;
         change_valid <= change_valid_nx;
         refund       <= refund_nx;
         refund_valid <= refund_valid_nx;
         coin_reject  <= coin_reject_nx;
         led          <= led_nx;
      end
   end

   always_comb begin
      state_nx = state_q;
      case (state_q)
         S_IDLE, S_COLLECT: begin
            if (cancel)
               state_nx = S_IDLE;
            else if (add != '0)
               state_nx = (new_credit >= PRICE_C) ? S_VEND : S_COLLECT;
            else if (state_q == S_COLLECT && inact_q == TO_LAST)
               state_nx = S_IDLE;
         end
         S_VEND: begin
            if (vend_cnt_q == VEND_LAST) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      inact_nx        = inact_q;
      vend_cnt_nx     = vend_cnt_q;
      step_cnt_nx     = step_cnt_q;
      change_due_nx   = change_due_q;
      credit_nx       = credit;
      change_nx       = change;
      refund_nx       = refund;
      led_nx          = led;
      vend_nx         = 1'b0;
      change_valid_nx = 1'b0;
      refund_valid_nx = 1'b0;
      coin_reject_nx  = 1'b0;
      case (state_q)
         S_IDLE, S_COLLECT: begin
            if (cancel) begin
               // Coins arriving with the cancel are returned, never vended.
               if (new_credit != '0) begin
                  refund_nx       = new_credit;
                  refund_valid_nx = 1'b1;
               end
               credit_nx = '0;
               inact_nx  = '0;
               led_nx    = '0;
            end else if (add != '0) begin
               if (new_credit >= PRICE_C) begin
                  vend_nx     = 1'b1;
                  credit_nx   = '0;
                  inact_nx    = '0;
                  vend_cnt_nx = '0;
                  step_cnt_nx = '0;
                  if (new_credit > PRICE_C) begin
                     change_nx       = new_credit - PRICE_C;
                     change_valid_nx = 1'b1;
                     change_due_nx   = 1'b1;
                     led_nx          = {1'b1, {(LED_W-1){1'b0}}};
                  end else begin
                     change_due_nx = 1'b0;
                     led_nx        = {{(LED_W-1){1'b0}}, 1'b1};
                  end
               end else begin
                  credit_nx = new_credit;
                  inact_nx  = '0;
                  led_nx    = therm(new_credit);
               end
            end else if (state_q == S_COLLECT) begin
               if (inact_q == TO_LAST) begin
                  refund_nx       = credit;
                  refund_valid_nx = 1'b1;
                  credit_nx       = '0;
                  inact_nx        = '0;
                  led_nx          = '0;
               end else begin
                  inact_nx = inact_q + 1'b1;
               end
            end
         end
         S_VEND: begin
            coin_reject_nx = coin_half | coin_one;
            if (vend_cnt_q == VEND_LAST) begin
               vend_cnt_nx = '0;
               step_cnt_nx = '0;
               led_nx      = '0;
            end else begin
               vend_cnt_nx = vend_cnt_q + 1'b1;
               if (step_cnt_q == STEP_LAST) begin
                  step_cnt_nx = '0;
                  // Left rotation for exact payment, right rotation when change was due.
                  led_nx = change_due_q ? {led[0], led[LED_W-1:1]}
                                        : {led[LED_W-2:0], led[LED_W-1]};
               end else begin
                  step_cnt_nx = step_cnt_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed table-driven bench for vend_ctrl_param with short timing parameters.
`timescale 1ns/1ps
module tb_vend_ctrl_param;

   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          coin_half = 1'b0;
   logic          coin_one = 1'b0;
   logic          cancel = 1'b0;
   logic [CW-1:0] credit, change, refund;
   logic          vend, change_valid, refund_valid, coin_reject;
   logic [7:0]    led;
   logic [1:0]    state_dbg;

   int n_vec  = 0;
   int n_fail = 0;

   vend_ctrl_param #(
      .PRICE_HALVES(5), .LED_W(8), .TIMEOUT_CYC(20), .STEP_CYC(4), .VEND_CYC(32)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .coin_half(coin_half), .coin_one(coin_one), .cancel(cancel),
      .credit(credit), .vend(vend), .change(change), .change_valid(change_valid),
      .refund(refund), .refund_valid(refund_valid), .coin_reject(coin_reject),
      .led(led), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            pre;
      logic          h, o, c;
      logic [CW-1:0] cr;
      logic          vd;
      logic [CW-1:0] ch;
      logic          cv;
      logic [CW-1:0] rf;
      logic          rv;
      logic          rej;
      logic [7:0]    ld;
      logic [1:0]    st;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int pre, logic h, logic o, logic c,
                               logic [CW-1:0] cr, logic vd, logic [CW-1:0] ch, logic cv,
                               logic [CW-1:0] rf, logic rv, logic rej,
                               logic [7:0] ld, logic [1:0] st);
      vec_t v;
      v.pre = pre; v.h = h; v.o = o; v.c = c;
      v.cr = cr; v.vd = vd; v.ch = ch; v.cv = cv;
      v.rf = rf; v.rv = rv; v.rej = rej; v.ld = ld; v.st = st;
      return v;
   endfunction

   task automatic compare(input string name, input vec_t v);
      logic [24:0] act, exp;
      act = {credit, vend, change, change_valid, refund, refund_valid, coin_reject, led, state_dbg};
      exp = {v.cr, v.vd, v.ch, v.cv, v.rf, v.rv, v.rej, v.ld, v.st};
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got cr=%0d vd=%0b ch=%0d cv=%0b rf=%0d rv=%0b rej=%0b led=%b st=%0d, want cr=%0d vd=%0b ch=%0d cv=%0b rf=%0d rv=%0b rej=%0b led=%b st=%0d",
                  name, credit, vend, change, change_valid, refund, refund_valid, coin_reject, led, state_dbg,
                  v.cr, v.vd, v.ch, v.cv, v.rf, v.rv, v.rej, v.ld, v.st);
      end
   endtask

   task automatic drive(input logic h, input logic o, input logic c);
      coin_half = h; coin_one = o; cancel = c;
   endtask

   // Called at a negedge; returns at the following negedge with inputs cleared.
   task automatic run_vec(input string name, input vec_t v);
      repeat (v.pre) begin
         drive(1'b0, 1'b0, 1'b0);
         @(posedge clk);
         @(negedge clk);
      end
      drive(v.h, v.o, v.c);
      @(posedge clk);
      #1;
      compare(name, v);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Exact payment, running light left, coin rejected during VEND
      tbl.push_back(mk( 0, 0,1,0, 2,0,0,0, 0,0,0, 8'h03, 1));
      tbl.push_back(mk( 0, 0,1,0, 4,0,0,0, 0,0,0, 8'h0F, 1));
      tbl.push_back(mk( 0, 1,0,0, 0,1,0,0, 0,0,0, 8'h01, 2));
      tbl.push_back(mk( 2, 0,0,0, 0,0,0,0, 0,0,0, 8'h01, 2));
      tbl.push_back(mk( 0, 0,0,0, 0,0,0,0, 0,0,0, 8'h02, 2));
      tbl.push_back(mk( 0, 0,1,0, 0,0,0,0, 0,0,1, 8'h02, 2));
      tbl.push_back(mk( 0, 0,0,0, 0,0,0,0, 0,0,0, 8'h02, 2));
      tbl.push_back(mk(24, 0,0,0, 0,0,0,0, 0,0,0, 8'h80, 2));
      tbl.push_back(mk( 0, 0,0,0, 0,0,0,0, 0,0,0, 8'h00, 0));
      // Overpayment by one half-unit, light runs right
      tbl.push_back(mk( 0, 0,1,0, 2,0,0,0, 0,0,0, 8'h03, 1));
      tbl.push_back(mk( 0, 0,1,0, 4,0,0,0, 0,0,0, 8'h0F, 1));
      tbl.push_back(mk( 0, 0,1,0, 0,1,1,1, 0,0,0, 8'h80, 2));
      tbl.push_back(mk( 0, 0,0,0, 0,0,1,0, 0,0,0, 8'h80, 2));
      tbl.push_back(mk( 2, 0,0,0, 0,0,1,0, 0,0,0, 8'h40, 2));
      tbl.push_back(mk(11, 0,0,0, 0,0,1,0, 0,0,0, 8'h08, 2));
      tbl.push_back(mk(11, 0,0,0, 0,0,1,0, 0,0,0, 8'h01, 2));
      tbl.push_back(mk( 3, 0,0,0, 0,0,1,0, 0,0,0, 8'h00, 0));
      // Both coins at once, then inactivity timeout one edge short and exact
      tbl.push_back(mk( 0, 1,1,0, 3,0,1,0, 0,0,0, 8'h07, 1));
      tbl.push_back(mk(18, 0,0,0, 3,0,1,0, 0,0,0, 8'h07, 1));
      tbl.push_back(mk( 0, 0,0,0, 0,0,1,0, 3,1,0, 8'h00, 0));
      tbl.push_back(mk( 0, 0,0,0, 0,0,1,0, 3,0,0, 8'h00, 0));
      // Cancel joined by a coin, cancel at exactly price, cancel in IDLE/COLLECT
      tbl.push_back(mk( 0, 0,1,0, 2,0,1,0, 3,0,0, 8'h03, 1));
      tbl.push_back(mk( 0, 1,0,1, 0,0,1,0, 3,1,0, 8'h00, 0));
      tbl.push_back(mk( 0, 0,1,0, 2,0,1,0, 3,0,0, 8'h03, 1));
      tbl.push_back(mk( 0, 0,1,0, 4,0,1,0, 3,0,0, 8'h0F, 1));
      tbl.push_back(mk( 0, 1,0,1, 0,0,1,0, 5,1,0, 8'h00, 0));
      tbl.push_back(mk( 0, 0,0,1, 0,0,1,0, 5,0,0, 8'h00, 0));
      tbl.push_back(mk( 0, 1,0,0, 1,0,1,0, 5,0,0, 8'h01, 1));
      tbl.push_back(mk( 0, 0,0,1, 0,0,1,0, 1,1,0, 8'h00, 0));
      // Maximum credit 7 -> change 2; coin on the last VEND edge rejected, next accepted
      tbl.push_back(mk( 0, 0,1,0, 2,0,1,0, 1,0,0, 8'h03, 1));
      tbl.push_back(mk( 0, 0,1,0, 4,0,1,0, 1,0,0, 8'h0F, 1));
      tbl.push_back(mk( 0, 1,1,0, 0,1,2,1, 1,0,0, 8'h80, 2));
      tbl.push_back(mk(30, 0,0,0, 0,0,2,0, 1,0,0, 8'h01, 2));
      tbl.push_back(mk( 0, 1,0,0, 0,0,2,0, 1,0,1, 8'h00, 0));
      tbl.push_back(mk( 0, 1,0,0, 1,0,2,0, 1,0,0, 8'h01, 1));
      // A coin restarts the inactivity count
      tbl.push_back(mk(15, 0,1,0, 3,0,2,0, 1,0,0, 8'h07, 1));
      tbl.push_back(mk(18, 0,0,0, 3,0,2,0, 1,0,0, 8'h07, 1));
      tbl.push_back(mk( 0, 0,0,0, 0,0,2,0, 3,1,0, 8'h00, 0));

      // Reset state
      rst_n = 1'b0;
      #12;
      compare("reset", mk(0, 0,0,0, 0,0,0,0, 0,0,0, 8'h00, 0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

      // Asynchronous reset mid-VEND with change pending
      run_vec("rv_c1", mk(0, 0,1,0, 2,0,2,0, 3,0,0, 8'h03, 1));
      run_vec("rv_c2", mk(0, 0,1,0, 4,0,2,0, 3,0,0, 8'h0F, 1));
      run_vec("rv_c3", mk(0, 0,1,0, 0,1,1,1, 3,0,0, 8'h80, 2));
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 compare("rst_mid_vend", mk(0, 0,0,0, 0,0,0,0, 0,0,0, 8'h00, 0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec("post_rst_vend", mk(0, 1,0,0, 1,0,0,0, 0,0,0, 8'h01, 1));

      // Asynchronous reset mid-COLLECT: credit lost, no refund pulse
      run_vec("rc_c1", mk(0, 0,1,0, 3,0,0,0, 0,0,0, 8'h07, 1));
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b0;
      #1 compare("rst_mid_collect", mk(0, 0,0,0, 0,0,0,0, 0,0,0, 8'h00, 0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec("post_rst_collect", mk(0, 1,0,0, 1,0,0,0, 0,0,0, 8'h01, 1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
